// File: rtl/sparsity_mask_reader.sv
// Fetches structured-sparsity bitmap words from the bitmap store and serializes
// them LSB-first into a keep/skip mask stream; dense mode emits all-ones without reads.
module sparsity_mask_reader #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       CONF_STR_SPARSITY,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_bits,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              mask_valid,
    input  logic              mask_ready,
    output logic              mask_bit,
    output logic              mask_last,
    output logic              busy,
    output logic              done
);
    localparam int IDX_W = $clog2(DATA_W);
    localparam int FW    = CNT_W + 1;
    localparam int LAT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_FETCH, S_STREAM, S_DONE} state_t;
    state_t state, state_next;

    logic              dense;
    logic [CNT_W-1:0]  remaining;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] cur_word;
    logic [DATA_W-1:0] pf_word;
    logic              cur_valid;
    logic              pf_valid;
    logic              pf_pending;
    logic [FW-1:0]     fetch_left;
    logic [LAT_W-1:0]  lat_cnt;

    logic              stream_valid;
    logic              hs;
    logic              lat_done;
    logic              word_adv;
    logic              cur_free;
    logic              is_dense_cfg;
    logic [FW-1:0]     words_calc;

    assign is_dense_cfg = (CONF_STR_SPARSITY == '0);
    assign words_calc   = ({1'b0, num_bits} + FW'(DATA_W - 1)) >> IDX_W;
    assign lat_done     = (lat_cnt == LAT_W'(RD_LAT));
    assign stream_valid = (state == S_STREAM) && (dense || cur_valid);
    assign hs           = stream_valid && mask_ready && !abort;
    assign word_adv     = hs && !dense && (bit_idx == IDX_W'(DATA_W - 1)) && (remaining != CNT_W'(1));
    // A captured word goes straight to the current register if it is empty or being vacated now.
    assign cur_free     = !cur_valid || (word_adv && !pf_valid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        mask_valid = 1'b0;
        mask_bit   = 1'b0;
        mask_last  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (num_bits == '0)
                        state_next = S_DONE;
                    else if (is_dense_cfg)
                        state_next = S_STREAM;
                    else
                        state_next = S_PRIME;
                end
            end
            S_PRIME: begin
                busy       = 1'b1;
                state_next = S_FETCH;
            end
            S_FETCH: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (lat_done)
                    state_next = S_STREAM;
            end
            S_STREAM: begin
                busy       = 1'b1;
                // Read enable falls once the final word's address has been held long enough.
                rd_en      = (fetch_left != '0) &&
                             !((fetch_left == FW'(1)) && pf_pending && !pf_valid && lat_done);
                mask_valid = stream_valid;
                mask_bit   = stream_valid && (dense || cur_word[bit_idx]);
                mask_last  = stream_valid && (remaining == CNT_W'(1));
                if (hs && (remaining == CNT_W'(1)))
                    state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (abort)
            state_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dense      <= 1'b0;
            remaining  <= '0;
            bit_idx    <= '0;
            cur_word   <= '0;
            pf_word    <= '0;
            cur_valid  <= 1'b0;
            pf_valid   <= 1'b0;
            pf_pending <= 1'b0;
            fetch_left <= '0;
            lat_cnt    <= '0;
            rd_addr    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        dense      <= is_dense_cfg;
                        remaining  <= num_bits;
                        bit_idx    <= '0;
                        cur_valid  <= 1'b0;
                        pf_valid   <= 1'b0;
                        pf_pending <= 1'b0;
                        lat_cnt    <= '0;
                        fetch_left <= is_dense_cfg ? '0 : words_calc;
                        // Flip the LSB first so the store sees an address change for the base read.
                        if (!is_dense_cfg && (num_bits != '0))
                            rd_addr <= base_addr ^ ADDR_W'(1);
                    end
                end
                S_PRIME: begin
                    rd_addr <= rd_addr ^ ADDR_W'(1);
                    lat_cnt <= '0;
                end
                S_FETCH: begin
                    if (lat_done) begin
                        cur_word   <= rd_data;
                        cur_valid  <= 1'b1;
                        rd_addr    <= rd_addr + ADDR_W'(1);
                        fetch_left <= fetch_left - FW'(1);
                        pf_pending <= (fetch_left > FW'(1));
                        lat_cnt    <= '0;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                S_STREAM: begin
                    if (hs) begin
                        remaining <= remaining - CNT_W'(1);
                        bit_idx   <= bit_idx + IDX_W'(1);
                    end
                    if (word_adv) begin
                        if (pf_valid) begin
                            cur_word <= pf_word;
                            pf_valid <= 1'b0;
                        end else begin
                            cur_valid <= 1'b0;
                        end
                    end
                    // Latency is counted only while the prefetch slot is free.
                    if (pf_pending && !pf_valid) begin
                        if (lat_done) begin
                            if (cur_free) begin
                                cur_word  <= rd_data;
                                cur_valid <= 1'b1;
                            end else begin
                                pf_word  <= rd_data;
                                pf_valid <= 1'b1;
                            end
                            rd_addr    <= rd_addr + ADDR_W'(1);
                            fetch_left <= fetch_left - FW'(1);
                            pf_pending <= (fetch_left > FW'(1));
                            lat_cnt    <= '0;
                        end else begin
                            lat_cnt <= lat_cnt + LAT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
            if (abort) begin
                cur_valid  <= 1'b0;
                pf_valid   <= 1'b0;
                pf_pending <= 1'b0;
                fetch_left <= '0;
            end
        end
    end
endmodule
